reg_bank_arbiter: RTL and testbench
===================================

# reg_bank_arbiter

Shares one bank of enable-gated register entries among four write requesters. Round-robin arbitration picks one request at a time and sequences a single-cycle write-enable into the addressed entry. A combinational read port is provided. The block sits between the design's functional units and the storage flops, and is the only agent that drives their enables.

## Interface
- `WIDTH`, 8: data bits per entry.
- `DEPTH`, 4: number of entries. Power of two, ≥2. `AW = $clog2(DEPTH)`.
- `RESET_VAL`, `{WIDTH{1'b0}}`: value every entry takes on reset and on clear.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_i`  in  4  write request, one bit per requester.
- `addr_i`  in  4*AW  target entry; requester r uses `addr_i[r*AW +: AW]`.
- `data_i`  in  4*WIDTH  write data; requester r uses `data_i[r*WIDTH +: WIDTH]`.
- `clr_i`  in  1  synchronous clear of all entries.
- `rd_addr_i`  in  AW  read address.
- `rd_data_o`  out  WIDTH  combinational read of entry `rd_addr_i`.
- `gnt_o`  out  4  one-hot grant pulse; marks the write cycle.
- `busy_o`  out  1  high while a write is in flight (state WRITE).

## Operation
- The FSM has two states, IDLE and WRITE. The reset state is IDLE.
- **IDLE:** if `req_i != 0`, choose a winner round-robin. Search starts at `last+1` mod 4 and takes the first set bit.
  - At the clock edge: latch winner index, `addr`, and `data` into internal registers; set `last` to the winner; go to WRITE.
  - If `req_i == 0`, stay in IDLE; `last` is unchanged.
- **WRITE:** `gnt_o` is one-hot on the latched winner and `busy_o=1`. The write-enable of the latched entry is high.
  - At the clock edge: the entry takes the latched data; go to IDLE unconditionally.
  - `req_i` is ignored in WRITE.
- Requests are level-sensitive. A requester holds `req`/`addr`/`data` stable until it sees its `gnt_o` bit, and drops `req` no later than the cycle after `gnt_o`.
  - A `req` still high at the next IDLE sampling edge is a new request.
  - Payload may change any time after the sampling edge; the latched copy is used.
- **Clear:** `clr_i=1` at an edge loads `RESET_VAL` into all entries. This happens in either state.
  - If it coincides with a WRITE edge, clear wins and the pending write is discarded.
  - `gnt_o` still pulses and the FSM still returns to IDLE.
  - Arbitration is unaffected by `clr_i`.
- **Reset:** `rst_n=0` asynchronously forces:
  - state to IDLE;
  - `gnt_o=0`, `busy_o=0`;
  - `last=3`, so requester 0 has first priority;
  - all entries to `RESET_VAL`, so `rd_data_o=RESET_VAL`;
  - latched addr/data to 0.
  - A reset during WRITE aborts the write; the entry keeps `RESET_VAL`.
- Writes to the same address by successive winners simply overwrite, last one wins. There is no address conflict logic.
- Each entry is a WIDTH-bit register with synchronous enable, priority order reset > clear > enable.

## Timing
- Request sampled at edge e0 (IDLE) → `gnt_o` and `busy_o` high for exactly one cycle (e0 to e1). Data is committed at e1 and visible on `rd_data_o` right after e1.
- Issue latency is 2 edges; throughput is one write per 2 cycles.
- Under continuous requests, grants alternate with one IDLE cycle between each WRITE.
- `gnt_o` never has more than one bit set. `busy_o == |gnt_o` always.
- The read path is combinational and has no read-during-write bypass. A read of the entry being written returns the old value until e1.
- Fairness: with all four requesting continuously, each requester is granted once per 8 cycles. No requester waits more than 3 grants.

## Test plan
- **Reset / first grant:** hold `rst_n=0`, then release with `req_i=4'b1111` → first grant is `gnt_o=4'b0001`, and `rd_data_o=RESET_VAL` for every `rd_addr_i`.
- **Single write:** r2 requests `addr=1`, `data=8'hA5` at edge e0 → `gnt_o=4'b0100` and `busy_o=1` in cycle e0–e1 → `rd_data_o=8'hA5` at `rd_addr_i=1` after e1; other entries unchanged.
- **Round-robin:** `req_i=4'b1111` held, with each requester dropping `req` after its grant and reasserting → grant order 0,1,2,3,0. With only r1 and r3 held → 1,3,1,3.
- **Clear collision:** `clr_i=1` on the WRITE edge of a write of `8'h3C` to entry 0 → all entries `RESET_VAL`, `gnt_o` still pulsed once, FSM back in IDLE.
- **Reset mid-write:** drop `rst_n` during WRITE → `gnt_o` and `busy_o` go 0 immediately, before the next edge, and the target entry stays `RESET_VAL`. After release, the first grant goes to requester 0 if it requests.
- **Payload change after sample:** r0 changes `data` from `8'h11` to `8'h22` in the WRITE cycle → entry holds `8'h11`.

Source files
------------

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: four requesters share one bank of enable-gated registers.
// A round-robin arbiter grants one write at a time. Each accepted write takes
// an IDLE->WRITE->IDLE round trip. Reads are combinational and unregistered.
module reg_bank_arbiter #(
  parameter int unsigned     WIDTH     = 8,
  parameter int unsigned     DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [3:0]                req_i,
  input  logic [4*$clog2(DEPTH)-1:0] addr_i,
  input  logic [4*WIDTH-1:0]        data_i,
  input  logic                      clr_i,
  input  logic [$clog2(DEPTH)-1:0]  rd_addr_i,
  output logic [WIDTH-1:0]          rd_data_o,
  output logic [3:0]                gnt_o,
  output logic                      busy_o
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned NREQ = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t             state;
  logic [1:0]         last;
  logic [AW-1:0]      addr_q;
  logic [WIDTH-1:0]   data_q;
  logic [1:0]         win_idx_c;
  logic               win_vld_c;
  logic               we_c;
  logic [WIDTH-1:0]   mem [DEPTH];

  // Round-robin pick: search starts one past the last winner and wraps.
  always_comb begin
    logic [1:0] idx;
    idx       = '0;
    win_idx_c = '0;
    win_vld_c = 1'b0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      idx = last + 2'(k);
      if (!win_vld_c && req_i[idx]) begin
        win_idx_c = idx;
        win_vld_c = 1'b1;
      end
    end
  end

  // Arbitration FSM: latches the winner's payload and pulses its grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      last   <= 2'd3;
      addr_q <= '0;
      data_q <= '0;
      gnt_o  <= '0;
      busy_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld_c) begin
            state  <= WRITE;
            last   <= win_idx_c;
            addr_q <= addr_i[int'(win_idx_c)*AW +: AW];
            data_q <= data_i[int'(win_idx_c)*WIDTH +: WIDTH];
            gnt_o  <= 4'b0001 << win_idx_c;
            busy_o <= 1'b1;
          end
        end
        WRITE: begin
          state  <= IDLE;
          gnt_o  <= '0;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          gnt_o  <= '0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  assign we_c = (state == WRITE);

  // Storage entries: reset beats clear, clear beats the write enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= RESET_VAL;
    end else if (clr_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= RESET_VAL;
    end else if (we_c) begin
      mem[addr_q] <= data_q;
    end
  end

  // Combinational read, no bypass of an in-flight write.
  assign rd_data_o = mem[rd_addr_i];

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: reset, round-robin order, single
// write, payload latching, clear collision and reset during WRITE.
module tb_reg_bank_arbiter;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [3:0]         req_i;
  logic [4*AW-1:0]    addr_i;
  logic [4*WIDTH-1:0] data_i;
  logic               clr_i;
  logic [AW-1:0]      rd_addr_i;
  logic [WIDTH-1:0]   rd_data_o;
  logic [3:0]         gnt_o;
  logic               busy_o;

  int total = 0;
  int bad   = 0;

  reg_bank_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(8'h00)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_i),
    .addr_i    (addr_i),
    .data_i    (data_i),
    .clr_i     (clr_i),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (rd_data_o),
    .gnt_o     (gnt_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_pay(input int r, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    addr_i[r*AW +: AW]       = a;
    data_i[r*WIDTH +: WIDTH] = d;
  endtask

  task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [WIDTH-1:0] exp);
    rd_addr_i = a;
    #1;
    chk(tag, 32'(rd_data_o), 32'(exp));
  endtask

  // One grant cycle: expect grant g on the next edge, then load the next request mask.
  task automatic grant_step(input string tag, input logic [3:0] g, input logic [3:0] next_req);
    tick();
    chk(tag, 32'(gnt_o), 32'(g));
    chk({tag, "_busy"}, 32'(busy_o), 32'd1);
    req_i = next_req;
    tick();
    chk({tag, "_idle"}, 32'(gnt_o), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_i = 4'b1111; addr_i = '0; data_i = '0; clr_i = 1'b0; rd_addr_i = '0;

    // Reset state
    tick();
    tick();
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    for (int i = 0; i < 4; i++) rd_chk("rst_rd", AW'(i), 8'h00);
    rst_n = 1'b1;

    // Round-robin with all four: 0,1,2,3,0
    grant_step("rr_g0", 4'b0001, 4'b1110);
    grant_step("rr_g1", 4'b0010, 4'b1101);
    grant_step("rr_g2", 4'b0100, 4'b1011);
    grant_step("rr_g3", 4'b1000, 4'b0111);
    grant_step("rr_g0b", 4'b0001, 4'b1010);

    // Only r1 and r3 held: 1,3,1,3
    grant_step("rr13_a", 4'b0010, 4'b1010);
    grant_step("rr13_b", 4'b1000, 4'b1010);
    grant_step("rr13_c", 4'b0010, 4'b1010);
    tick();
    chk("rr13_d", 32'(gnt_o), 32'b1000);
    req_i = 4'b0000;
    tick();

    // Single write from r2: entry 1 <= A5, old value visible during WRITE
    set_pay(2, 2'd1, 8'hA5);
    req_i = 4'b0100;
    tick();
    chk("sw_gnt", 32'(gnt_o), 32'b0100);
    chk("sw_busy", 32'(busy_o), 32'd1);
    rd_chk("sw_old", 2'd1, 8'h00);
    req_i = 4'b0000;
    tick();
    chk("sw_done_busy", 32'(busy_o), 32'd0);
    rd_chk("sw_new", 2'd1, 8'hA5);
    rd_chk("sw_e0", 2'd0, 8'h00);
    rd_chk("sw_e2", 2'd2, 8'h00);
    rd_chk("sw_e3", 2'd3, 8'h00);

    // Payload change after sampling: latched 11 wins over 22
    set_pay(0, 2'd2, 8'h11);
    req_i = 4'b0001;
    tick();
    chk("pl_gnt", 32'(gnt_o), 32'b0001);
    set_pay(0, 2'd2, 8'h22);
    req_i = 4'b0000;
    tick();
    rd_chk("pl_val", 2'd2, 8'h11);

    // Clear on the WRITE edge of a 3C write to entry 0
    set_pay(0, 2'd0, 8'h3C);
    req_i = 4'b0001;
    tick();
    chk("clr_gnt", 32'(gnt_o), 32'b0001);
    clr_i = 1'b1;
    req_i = 4'b0000;
    tick();
    clr_i = 1'b0;
    chk("clr_gnt_off", 32'(gnt_o), 32'd0);
    chk("clr_busy_off", 32'(busy_o), 32'd0);
    for (int i = 0; i < 4; i++) rd_chk("clr_rd", AW'(i), 8'h00);
    set_pay(1, 2'd3, 8'h5A);
    req_i = 4'b0010;
    tick();
    chk("clr_idle_gnt", 32'(gnt_o), 32'b0010);

    // Reset during WRITE: outputs drop at once, write aborted
    req_i = 4'b0000;
    rst_n = 1'b0;
    #1;
    chk("rmw_gnt", 32'(gnt_o), 32'd0);
    chk("rmw_busy", 32'(busy_o), 32'd0);
    tick();
    rd_chk("rmw_e3", 2'd3, 8'h00);
    rst_n = 1'b1;
    req_i = 4'b1111;
    tick();
    chk("rmw_first", 32'(gnt_o), 32'b0001);
    req_i = 4'b0000;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
